// File: rtl/sppm_pulse_gen.sv
// SPPM pulse source: spreads `rate` single-edge pulses evenly over each window
// with a phase accumulator and reports how many pulses left the block per window.
module sppm_pulse_gen #(
    parameter int CLK_PER_MS = 400000,
    parameter int RATE_W     = 17,
    parameter int PW_W       = 4,
    parameter int PEND_MAX   = 15
) (
    input  logic              clk400M,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [RATE_W-1:0] rate,
    input  logic [PW_W-1:0]   pulse_width,
    output logic              sppm,
    output logic              window_tick,
    output logic [RATE_W-1:0] sent_1ms,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    localparam int ACC_W  = 20;
    localparam int WC_W   = $clog2(CLK_PER_MS);
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(CLK_PER_MS - 1);
    localparam logic [ACC_W:0]    PERIOD   = (ACC_W + 1)'(CLK_PER_MS);
    localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [WC_W-1:0]   wcnt;
    logic [ACC_W-1:0]  acc;
    logic [RATE_W-1:0] rate_lat;
    logic [RATE_W-1:0] sent_cnt;
    logic [PEND_W-1:0] pend;
    logic [PW_W-1:0]   wc;

    logic              wrap;
    logic [ACC_W:0]    acc_sum;
    logic              fire;
    logic              launch;
    logic [PW_W-1:0]   wc_load;

    assign wrap        = (wcnt == WC_LAST);
    assign window_tick = wrap;
    assign state_dbg   = state;

    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(rate_lat);
    assign fire    = enable && (acc_sum >= PERIOD);

    // Launching from GAP keeps the single low cycle while allowing a
    // back-to-back period of width+1 when requests are queued.
    assign launch  = enable && ((state == IDLE) || (state == GAP)) &&
                     ((pend != '0) || fire);
    assign wc_load = (pulse_width == '0) ? '0 : pulse_width - 1'b1;

    always_ff @(posedge clk400M) begin
        if (!rst_n) begin
            state    <= IDLE;
            wcnt     <= '0;
            acc      <= '0;
            rate_lat <= '0;
            sent_cnt <= '0;
            sent_1ms <= '0;
            pend     <= '0;
            wc       <= '0;
            sppm     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wcnt <= wrap ? '0 : wcnt + 1'b1;

            // A launch in the wrap cycle belongs to the window that starts next.
            if (wrap) begin
                rate_lat <= rate;
                acc      <= '0;
                sent_1ms <= sent_cnt;
                sent_cnt <= RATE_W'(launch);
            end else begin
                sent_cnt <= sent_cnt + RATE_W'(launch);
                if (!enable)
                    acc <= '0;
                else if (fire)
                    acc <= ACC_W'(acc_sum - PERIOD);
                else
                    acc <= acc_sum[ACC_W-1:0];
            end

            if (!enable) begin
                pend <= '0;
            end else if (fire && !launch) begin
                if (pend == PEND_TOP)
                    overflow <= 1'b1;
                else
                    pend <= pend + 1'b1;
            end else if (!fire && launch) begin
                pend <= pend - 1'b1;
            end

            case (state)
                IDLE, GAP: begin
                    if (launch) begin
                        state <= HIGH;
                        sppm  <= 1'b1;
                        wc    <= wc_load;
                    end else begin
                        state <= IDLE;
                        sppm  <= 1'b0;
                    end
                end
                HIGH: begin
                    if (wc != '0) begin
                        wc <= wc - 1'b1;
                    end else begin
                        state <= GAP;
                        sppm  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sppm  <= 1'b0;
                end
            endcase
        end
    end

endmodule
